hrm_ctl: RTL and testbench
==========================

# hrm_ctl

Control sequencer for the HRM CPU datapath.
- Drives the load strobe of the instruction register (`wIR`), the program counter, the operand register, the data RAM, the accumulator and the inbox/outbox handshakes.
- Moves each instruction through fetch, optional operand fetch, optional RAM read and execute.
- Sits between the program/data memories, the IR, the ALU/accumulator and the IO queues; it is the only block that asserts their write enables.

## Interface
Parameters:
- `SW`, 4, width of `state` debug output.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock, all state changes on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `rIR`  in  8  current IR contents; opcode = `rIR[7:4]`
- `inbox_empty`  in  1  inbox queue has no data
- `outbox_full`  in  1  outbox queue cannot accept
- `acc_zero`  in  1  accumulator == 0
- `acc_neg`  in  1  accumulator sign bit
- `wIR`  out  1  load IR from program memory data
- `wPC`  out  1  load PC
- `pc_sel`  out  1  0 = PC+1, 1 = jump target (operand register)
- `wM2`  out  1  load operand register from program memory data
- `ram_rd`  out  1  data RAM read at operand address
- `wRam`  out  1  data RAM write at operand address
- `wR`  out  1  load accumulator from ALU
- `alu_op`  out  3  0 PASS_IN, 1 PASS_M, 2 ADD, 3 SUB, 4 INC, 5 DEC
- `inbox_rd`  out  1  pop inbox
- `outbox_wr`  out  1  push accumulator to outbox
- `halted`  out  1  sticky halt indication
- `state`  out  SW  current state encoding

## Operation
Opcodes:
- 0 INBOX, 1 OUTBOX, 2 COPYFROM, 3 COPYTO, 4 ADD, 5 SUB, 6 BUMPUP, 7 BUMPDN, 8 JUMP, 9 JUMPZ, A JUMPN, F HALT.
- B–E are illegal and behave as HALT.
- Two-byte (operand follows): 2–A.
- Needs RAM read: 2, 4, 5, 6, 7.

States and transitions:
- FETCH → LOAD_IR. Program memory is addressed by PC; 1-cycle synchronous read.
- LOAD_IR: `wIR`=1, `wPC`=1, `pc_sel`=0 → DECODE.
- DECODE:
  - HALT/illegal → HALT.
  - Two-byte → OPF.
  - Otherwise → EXEC.
- OPF → LOAD_OP.
- LOAD_OP: `wM2`=1, `wPC`=1, `pc_sel`=0.
  - Needs RAM read → MEMRD.
  - Otherwise → EXEC.
- MEMRD: `ram_rd`=1 → EXEC.
- EXEC (→ FETCH unless stalled):
  - INBOX: when `inbox_empty`=0, `inbox_rd`=1, `wR`=1, `alu_op`=PASS_IN. While empty, stay in EXEC with all strobes 0.
  - OUTBOX: when `outbox_full`=0, `outbox_wr`=1. While full, stay in EXEC with all strobes 0.
  - COPYFROM: `wR`, PASS_M.
  - COPYTO: `wRam`.
  - ADD/SUB: `wR`, ADD/SUB.
  - BUMPUP/BUMPDN: `wR`=1 and `wRam`=1, INC/DEC.
  - JUMP: `wPC`=1, `pc_sel`=1.
  - JUMPZ/JUMPN: same as JUMP, only if `acc_zero`/`acc_neg` is sampled in EXEC; else no strobe.
- HALT: `halted`=1, absorbing until reset.

Output rules:
- All outputs are a function of the state register, `rIR` and the IO/flag inputs in the current cycle.
- Every strobe is 1 cycle wide, except IO strobes, which assert only in the cycle the handshake completes.

## Timing
- Cycles per instruction:
  - 4: INBOX, OUTBOX (plus stall cycles).
  - 6: COPYTO, JUMP, JUMPZ, JUMPN.
  - 7: COPYFROM, ADD, SUB, BUMPUP, BUMPDN.
- PC increments exactly twice per two-byte instruction and once per one-byte instruction. A taken jump overrides in EXEC.
- Reset (`rst_n`=0 at a rising edge):
  - Next cycle `state`=FETCH and `halted`=0.
  - All strobes are 0 and `alu_op`=0.
  - Applies from any state, including mid-stall and HALT. No partial writes follow.
- While `rst_n`=0: all strobes are forced 0.
- Simultaneous cases:
  - `inbox_empty` deasserting in the same cycle the bench checks EXEC → handshake completes that cycle.
  - Flags are sampled only in EXEC; changes in other states are ignored.

## Structure
- Shared package `hrm_pkg`:
  - opcode localparams
  - state encoding (FETCH=0, LOAD_IR=1, DECODE=2, OPF=3, LOAD_OP=4, MEMRD=5, EXEC=6, HALT=7)
  - `alu_op` encoding
- Sub-module `hrm_decode` (combinational): `rIR` → `two_byte`, `needs_mem`, `is_jump`, `legal`, `alu_op`.
- `hrm_ctl` holds the state register and strobe generation.

## Test plan
- Reset, then INBOX (`rIR`=0x00) with `inbox_empty`=1 for 3 cycles → FETCH, LOAD_IR (`wIR`=1), DECODE, then EXEC held 3 cycles with no strobes. When empty drops: `inbox_rd`=`wR`=1 for 1 cycle, then FETCH.
- ADD (`rIR`=0x40) → `wM2` in cycle 5, `ram_rd` in cycle 6, `wR`=1 with `alu_op`=2 in cycle 7. `wPC` pulses exactly twice.
- JUMPZ (0x90) with `acc_zero`=0 → no `wPC` in EXEC. Repeat with `acc_zero`=1 → `wPC`=1, `pc_sel`=1 in cycle 6.
- BUMPDN (0x70) → `wR` and `wRam` both 1 in the same EXEC cycle, `alu_op`=5.
- HALT (0xF0) and illegal (0xC0) → `halted`=1 from cycle 4, no further strobes. `rst_n`=0 → next cycle `state`=0, `halted`=0.
- `rst_n`=0 asserted during OUTBOX stall (`outbox_full`=1) → `outbox_wr` never asserted; `state`=FETCH after one edge.

Source files
------------

// File: rtl/hrm_pkg.sv
// Shared definitions for the HRM control sequencer: opcodes, FSM states, ALU ops.
package hrm_pkg;

    localparam logic [3:0] OP_INBOX    = 4'h0;
    localparam logic [3:0] OP_OUTBOX   = 4'h1;
    localparam logic [3:0] OP_COPYFROM = 4'h2;
    localparam logic [3:0] OP_COPYTO   = 4'h3;
    localparam logic [3:0] OP_ADD      = 4'h4;
    localparam logic [3:0] OP_SUB      = 4'h5;
    localparam logic [3:0] OP_BUMPUP   = 4'h6;
    localparam logic [3:0] OP_BUMPDN   = 4'h7;
    localparam logic [3:0] OP_JUMP     = 4'h8;
    localparam logic [3:0] OP_JUMPZ    = 4'h9;
    localparam logic [3:0] OP_JUMPN    = 4'hA;
    localparam logic [3:0] OP_HALT     = 4'hF;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_LOAD_IR = 4'd1,
        ST_DECODE  = 4'd2,
        ST_OPF     = 4'd3,
        ST_LOAD_OP = 4'd4,
        ST_MEMRD   = 4'd5,
        ST_EXEC    = 4'd6,
        ST_HALT    = 4'd7
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS_IN = 3'd0,
        ALU_PASS_M  = 3'd1,
        ALU_ADD     = 3'd2,
        ALU_SUB     = 3'd3,
        ALU_INC     = 3'd4,
        ALU_DEC     = 3'd5
    } alu_op_t;

endpackage

// File: rtl/hrm_ctl_if.sv
// Control bundle between the sequencer and the HRM datapath / IO queues.
interface hrm_ctl_if #(
    parameter int SW = 4
);
    logic [7:0]    rIR;
    logic          inbox_empty;
    logic          outbox_full;
    logic          acc_zero;
    logic          acc_neg;
    logic          wIR;
    logic          wPC;
    logic          pc_sel;
    logic          wM2;
    logic          ram_rd;
    logic          wRam;
    logic          wR;
    logic [2:0]    alu_op;
    logic          inbox_rd;
    logic          outbox_wr;
    logic          halted;
    logic [SW-1:0] state;

    // Sequencer side
    modport master (
        input  rIR, inbox_empty, outbox_full, acc_zero, acc_neg,
        output wIR, wPC, pc_sel, wM2, ram_rd, wRam, wR, alu_op,
               inbox_rd, outbox_wr, halted, state
    );

    // Datapath side
    modport slave (
        output rIR, inbox_empty, outbox_full, acc_zero, acc_neg,
        input  wIR, wPC, pc_sel, wM2, ram_rd, wRam, wR, alu_op,
               inbox_rd, outbox_wr, halted, state
    );
endinterface

// File: rtl/hrm_ctl_decode.sv
// Combinational opcode classifier for the HRM sequencer.
module hrm_decode
    import hrm_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       two_byte,
    output logic       needs_mem,
    output logic       is_jump,
    output logic       legal,
    output alu_op_t    alu_op
);

    // Classify the opcode into instruction properties and its ALU function
    always_comb begin
        two_byte  = 1'b0;
        needs_mem = 1'b0;
        is_jump   = 1'b0;
        legal     = 1'b1;
        alu_op    = ALU_PASS_IN;
        case (opcode)
            OP_INBOX:    alu_op = ALU_PASS_IN;
            OP_OUTBOX:   ;
            OP_COPYFROM: begin two_byte = 1'b1; needs_mem = 1'b1; alu_op = ALU_PASS_M; end
            OP_COPYTO:   two_byte = 1'b1;
            OP_ADD:      begin two_byte = 1'b1; needs_mem = 1'b1; alu_op = ALU_ADD; end
            OP_SUB:      begin two_byte = 1'b1; needs_mem = 1'b1; alu_op = ALU_SUB; end
            OP_BUMPUP:   begin two_byte = 1'b1; needs_mem = 1'b1; alu_op = ALU_INC; end
            OP_BUMPDN:   begin two_byte = 1'b1; needs_mem = 1'b1; alu_op = ALU_DEC; end
            OP_JUMP,
            OP_JUMPZ,
            OP_JUMPN:    begin two_byte = 1'b1; is_jump = 1'b1; end
            default:     legal = 1'b0;  // HALT and the illegal B..E codes
        endcase
    end

endmodule

// File: rtl/hrm_ctl.sv
// HRM CPU control sequencer: fetch / operand fetch / RAM read / execute FSM.
module hrm_ctl
    import hrm_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    hrm_ctl_if.master  bus
);

    state_t     cur_state;
    state_t     nxt_state;
    logic [3:0] opcode;
    logic       two_byte;
    logic       needs_mem;
    logic       is_jump;
    logic       legal;
    alu_op_t    dec_alu;
    logic       stall;
    logic       jump_taken;

    logic       wir_q, wpc_q, pc_sel_q, wm2_q, ram_rd_q, wram_q, wr_q;
    logic       inbox_rd_q, outbox_wr_q;
    logic [2:0] alu_op_q;

    assign opcode = bus.rIR[7:4];

    hrm_decode u_decode (
        .opcode    (opcode),
        .two_byte  (two_byte),
        .needs_mem (needs_mem),
        .is_jump   (is_jump),
        .legal     (legal),
        .alu_op    (dec_alu)
    );

    // IO instructions wait in EXEC until their queue handshake can complete
    assign stall = ((opcode == OP_INBOX)  && bus.inbox_empty) ||
                   ((opcode == OP_OUTBOX) && bus.outbox_full);

    assign jump_taken = is_jump && ((opcode == OP_JUMP) ||
                                    ((opcode == OP_JUMPZ) && bus.acc_zero) ||
                                    ((opcode == OP_JUMPN) && bus.acc_neg));

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) cur_state <= ST_FETCH;
        else        cur_state <= nxt_state;
    end

    // Next-state selection
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            ST_FETCH:   nxt_state = ST_LOAD_IR;
            ST_LOAD_IR: nxt_state = ST_DECODE;
            ST_DECODE: begin
                if (!legal)        nxt_state = ST_HALT;
                else if (two_byte) nxt_state = ST_OPF;
                else               nxt_state = ST_EXEC;
            end
            ST_OPF:     nxt_state = ST_LOAD_OP;
            ST_LOAD_OP: nxt_state = needs_mem ? ST_MEMRD : ST_EXEC;
            ST_MEMRD:   nxt_state = ST_EXEC;
            ST_EXEC:    nxt_state = stall ? ST_EXEC : ST_FETCH;
            ST_HALT:    nxt_state = ST_HALT;
            default:    nxt_state = ST_FETCH;
        endcase
    end

    // Strobe generation; everything is forced low while reset is held
    always_comb begin
        wir_q       = 1'b0;
        wpc_q       = 1'b0;
        pc_sel_q    = 1'b0;
        wm2_q       = 1'b0;
        ram_rd_q    = 1'b0;
        wram_q      = 1'b0;
        wr_q        = 1'b0;
        inbox_rd_q  = 1'b0;
        outbox_wr_q = 1'b0;
        alu_op_q    = '0;
        case (cur_state)
            ST_LOAD_IR: begin
                wir_q = 1'b1;
                wpc_q = 1'b1;
            end
            ST_LOAD_OP: begin
                wm2_q = 1'b1;
                wpc_q = 1'b1;
            end
            ST_MEMRD: ram_rd_q = 1'b1;
            ST_EXEC: begin
                case (opcode)
                    OP_INBOX: begin
                        if (!bus.inbox_empty) begin
                            inbox_rd_q = 1'b1;
                            wr_q       = 1'b1;
                        end
                    end
                    OP_OUTBOX:   outbox_wr_q = !bus.outbox_full;
                    OP_COPYFROM,
                    OP_ADD,
                    OP_SUB:      wr_q = 1'b1;
                    OP_COPYTO:   wram_q = 1'b1;
                    OP_BUMPUP,
                    OP_BUMPDN: begin
                        wr_q   = 1'b1;
                        wram_q = 1'b1;
                    end
                    default: begin
                        wpc_q    = jump_taken;
                        pc_sel_q = jump_taken;
                    end
                endcase
                if (wr_q) alu_op_q = dec_alu;
            end
            default: ;
        endcase
        if (!rst_n) begin
            wir_q       = 1'b0;
            wpc_q       = 1'b0;
            pc_sel_q    = 1'b0;
            wm2_q       = 1'b0;
            ram_rd_q    = 1'b0;
            wram_q      = 1'b0;
            wr_q        = 1'b0;
            inbox_rd_q  = 1'b0;
            outbox_wr_q = 1'b0;
            alu_op_q    = '0;
        end
    end

    assign bus.wIR       = wir_q;
    assign bus.wPC       = wpc_q;
    assign bus.pc_sel    = pc_sel_q;
    assign bus.wM2       = wm2_q;
    assign bus.ram_rd    = ram_rd_q;
    assign bus.wRam      = wram_q;
    assign bus.wR        = wr_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.inbox_rd  = inbox_rd_q;
    assign bus.outbox_wr = outbox_wr_q;
    assign bus.halted    = (cur_state == ST_HALT);
    assign bus.state     = SW'(cur_state);

endmodule

// File: tb/tb_hrm_ctl.sv
// Self-checking bench for hrm_ctl: directed scenarios plus random instruction stream.
module tb_hrm_ctl;

    localparam logic [12:0] M_WIR  = 13'h1000;
    localparam logic [12:0] M_WPC  = 13'h0800;
    localparam logic [12:0] M_PCS  = 13'h0400;
    localparam logic [12:0] M_WM2  = 13'h0200;
    localparam logic [12:0] M_RRD  = 13'h0100;
    localparam logic [12:0] M_WRAM = 13'h0080;
    localparam logic [12:0] M_WR   = 13'h0040;
    localparam logic [12:0] M_IRD  = 13'h0004;
    localparam logic [12:0] M_OWR  = 13'h0002;
    localparam logic [12:0] M_HLT  = 13'h0001;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total    = 0;

    always #5 clk = ~clk;

    hrm_ctl_if #(.SW(4)) bus ();

    hrm_ctl #(.SW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [12:0] alu(input int a);
        return 13'(a) << 3;
    endfunction

    function automatic logic [12:0] obs();
        return {bus.wIR, bus.wPC, bus.pc_sel, bus.wM2, bus.ram_rd, bus.wRam, bus.wR,
                bus.alu_op, bus.inbox_rd, bus.outbox_wr, bus.halted};
    endfunction

    // Inputs the sequencer must ignore outside EXEC get random values
    task automatic noise();
        bus.inbox_empty = 1'($urandom);
        bus.outbox_full = 1'($urandom);
        bus.acc_zero    = 1'($urandom);
        bus.acc_neg     = 1'($urandom);
    endtask

    task automatic cyc(input logic [3:0] es, input logic [12:0] ev, input string tag);
        @(negedge clk);
        total++;
        assert (bus.state === es) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s state: got %0d want %0d", tag, bus.state, es);
        end
        total++;
        assert (obs() === ev) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s strobes: got %b want %b", tag, obs(), ev);
        end
        @(posedge clk);
        #1;
    endtask

    // Reference: expected cycle-by-cycle trace of one instruction from its opcode
    task automatic run_instr(input logic [7:0] ir, input int stalls,
                             input logic zf, input logic nf);
        logic [3:0]  opc;
        logic [12:0] ev;
        opc = ir[7:4];
        bus.rIR = ir;
        noise(); cyc(4'd0, '0, "fetch");
        noise(); cyc(4'd1, M_WIR | M_WPC, "load_ir");
        noise(); cyc(4'd2, '0, "decode");
        if (opc >= 4'hB) begin
            for (int i = 0; i < 3; i++) begin
                noise(); cyc(4'd7, M_HLT, "halt");
            end
            return;
        end
        if (opc >= 4'h2) begin
            noise(); cyc(4'd3, '0, "opf");
            noise(); cyc(4'd4, M_WM2 | M_WPC, "load_op");
            if (opc == 4'h2 || (opc >= 4'h4 && opc <= 4'h7)) begin
                noise(); cyc(4'd5, M_RRD, "memrd");
            end
        end
        noise();
        bus.acc_zero = zf;
        bus.acc_neg  = nf;
        for (int s = 0; s < stalls && opc <= 4'h1; s++) begin
            if (opc == 4'h0) bus.inbox_empty = 1'b1;
            else             bus.outbox_full = 1'b1;
            cyc(4'd6, '0, "io_stall");
        end
        bus.inbox_empty = 1'b0;
        bus.outbox_full = 1'b0;
        case (opc)
            4'h0: ev = M_IRD | M_WR | alu(0);
            4'h1: ev = M_OWR;
            4'h2: ev = M_WR | alu(1);
            4'h3: ev = M_WRAM;
            4'h4: ev = M_WR | alu(2);
            4'h5: ev = M_WR | alu(3);
            4'h6: ev = M_WR | M_WRAM | alu(4);
            4'h7: ev = M_WR | M_WRAM | alu(5);
            4'h8: ev = M_WPC | M_PCS;
            4'h9: ev = zf ? (M_WPC | M_PCS) : '0;
            default: ev = nf ? (M_WPC | M_PCS) : '0;
        endcase
        cyc(4'd6, ev, "exec");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.rIR = 8'h00;
        noise();
        @(posedge clk);
        #1;
        noise(); cyc(4'd0, '0, "reset");
        rst_n = 1'b1;

        // Directed scenarios
        run_instr(8'h00, 3, 1'b0, 1'b0);
        run_instr(8'h40, 0, 1'b0, 1'b0);
        run_instr(8'h90, 0, 1'b0, 1'b1);
        run_instr(8'h90, 0, 1'b1, 1'b0);
        run_instr(8'hA5, 0, 1'b0, 1'b1);
        run_instr(8'h70, 0, 1'b0, 1'b0);
        run_instr(8'h11, 2, 1'b0, 1'b0);

        run_instr(8'hF0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        noise(); cyc(4'd7, M_HLT, "rst_in_halt");
        rst_n = 1'b1;
        run_instr(8'h30, 0, 1'b1, 1'b1);
        run_instr(8'hC0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        noise(); cyc(4'd7, M_HLT, "rst_in_illegal");
        rst_n = 1'b1;

        // Reset during a strobe cycle: strobes must be suppressed
        bus.rIR = 8'h40;
        noise(); cyc(4'd0, '0, "fetch_pre_rst");
        rst_n = 1'b0;
        noise(); cyc(4'd1, '0, "rst_forced_load_ir");
        rst_n = 1'b1;

        // Reset during an OUTBOX stall, with the queue freeing in that same cycle
        bus.rIR = 8'h10;
        noise(); cyc(4'd0, '0, "ob_fetch");
        noise(); cyc(4'd1, M_WIR | M_WPC, "ob_load_ir");
        noise(); cyc(4'd2, '0, "ob_decode");
        bus.outbox_full = 1'b1;
        cyc(4'd6, '0, "ob_stall");
        cyc(4'd6, '0, "ob_stall");
        bus.outbox_full = 1'b0;
        rst_n = 1'b0;
        cyc(4'd6, '0, "ob_rst");
        rst_n = 1'b1;

        // Random instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [7:0] ir;
            ir[7:4] = 4'($urandom_range(0, 10));
            ir[3:0] = 4'($urandom);
            run_instr(ir, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
